psram_arbiter: RTL and testbench
================================

Name: psram_arbiter

Overview:
Two-port arbiter and transaction sequencer in front of the PSRAM QPI command engine. It shares the single PSRAM between a capture writer (port A) and a host reader/writer (port B) using round-robin grants. It latches each request, drives one start pulse plus a stable command to the engine, waits for completion with a timeout, returns read data, and enforces a CE-high gap between transactions. It sits between the application logic and the PSRAM driver, and it issues no grant until PSRAM initialisation (RSTEN/RST/SPI2QPI) reports done.

Parameters:
ADDR_W, 24, PSRAM byte address width
DATA_W, 16, data word width per transaction
TIMEOUT, 1023, max cycles to wait for mem_done before aborting (>=1)
GAP_CYCLES, 2, idle cycles forced after each transaction, tCPH margin (>=1)

Ports:
clk  in  1  system clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
init_done  in  1  PSRAM init sequence complete, level
a_req  in  1  port A request, level, held until a_ack
a_we  in  1  port A 1=write 0=read
a_addr  in  ADDR_W  port A address
a_wdata  in  DATA_W  port A write data
a_ack  out  1  port A completion pulse, 1 cycle
a_rdata  out  DATA_W  port A read data, valid with a_ack
b_req, b_we, b_addr, b_wdata, b_ack, b_rdata  same as port A, for port B
err  out  1  pulse with ack when that transaction timed out
timeout_err  out  1  sticky timeout flag, cleared only by rst_n
busy  out  1  high in every state except IDLE
mem_start  out  1  1-cycle start pulse to the PSRAM engine
mem_read  out  1  read command, stable from mem_start until done
mem_write  out  1  write command, stable from mem_start until done
mem_addr  out  ADDR_W  latched address
mem_wdata  out  DATA_W  latched write data
mem_done  in  1  engine completion pulse (endcommand)
mem_rdata  in  DATA_W  engine read data, valid with mem_done

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; rdata regs 0; last_grant=B, so A wins the first tie; timer 0.
- States: IDLE, ISSUE, WAIT, GAP.
- IDLE: if init_done=0, stay in IDLE and ignore all requests.
- IDLE, single request: grant that port.
- IDLE, both requests: grant the port not in last_grant. Update last_grant on grant.
- IDLE, on grant: latch we/addr/wdata into mem_* regs and go to ISSUE.
- ISSUE (1 cycle): mem_start=1; mem_read=~we; mem_write=we; go to WAIT.
- Latency: req sampled at edge k, mem_start high in cycle k+1.
- WAIT: mem_read/mem_write/mem_addr/mem_wdata held stable; timer increments each cycle.
- WAIT, mem_done=1: for a read, capture mem_rdata into the granted port's rdata. Pulse that port's ack for 1 cycle in the next cycle, then go to GAP. Write acks leave rdata unchanged.
- WAIT, timer reaches TIMEOUT without mem_done: pulse ack+err, set timeout_err, leave rdata unchanged, go to GAP.
- mem_done and timeout on the same cycle: done wins and err stays 0.
- GAP: mem_read=mem_write=0; count GAP_CYCLES; then return to IDLE.
- Requesters drop req the cycle after ack. Because GAP_CYCLES>=1, a req still high when IDLE is re-entered counts as a new request.
- mem_done outside WAIT: ignored.
- init_done falling mid-transaction: the current transaction completes normally; no new grant until it rises again.
- Request-signal changes after grant: no effect, because the command is latched.
- Timer width: clog2(TIMEOUT+1). Timer clears on every entry to WAIT and GAP.

Decomposition:
- Package psram_pkg holds the state encoding (IDLE/ISSUE/WAIT/GAP), port IDs (PORT_A=0, PORT_B=1), and the shared PSRAM command constants (CMD_READ 8'hEB, CMD_WRITE 8'h02, CMD_RSTEN 8'h66, CMD_RST 8'h99, SPI2QPI 8'h35) reused by the engine.
- Sub-module psram_rr_arb: 2-way round-robin grant from {a_req,b_req}, last_grant, and an enable input; purely combinational grant plus a registered pointer.

Test Plan:
1. init_done=0, a_req=1 for 50 cycles -> mem_start never pulses, busy=0. Raise init_done -> mem_start 1 cycle later with mem_addr=a_addr.
2. a_req read at 24'h000100; engine returns mem_done with mem_rdata=16'hBEEF after 8 cycles -> a_ack 1 cycle with a_rdata=16'hBEEF, err=0, then GAP_CYCLES idle before the next start.
3. a_req and b_req both held, each dropped after its ack and re-raised 1 cycle later, for 4 transactions -> grant order A,B,A,B; no port is granted twice in a row.
4. b_req write 16'h1234 to 24'hABCDEF; b_addr/b_wdata changed after the grant -> mem_addr=24'hABCDEF and mem_wdata=16'h1234 held through WAIT; mem_write=1, mem_read=0.
5. Engine never asserts mem_done, TIMEOUT=15 -> ack+err pulse 15 cycles after WAIT entry; timeout_err stays 1 until rst_n; the next request is still served.
6. rst_n asserted in WAIT -> all outputs 0 immediately. After release, the next tie grants port A first.

Source files
------------

// File: rtl/psram_pkg.sv
// Shared PSRAM definitions: arbiter state encoding, port IDs and the QPI
// command bytes also used by the command engine.
package psram_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam logic [7:0] CMD_READ    = 8'hEB;
  localparam logic [7:0] CMD_WRITE   = 8'h02;
  localparam logic [7:0] CMD_RSTEN   = 8'h66;
  localparam logic [7:0] CMD_RST     = 8'h99;
  localparam logic [7:0] CMD_SPI2QPI = 8'h35;

  // On a tie the port that did not win last time is chosen.
  function automatic logic rr_pick(input logic req_a, input logic req_b,
                                   input logic last_grant);
    if (req_a && req_b) return ~last_grant;
    else if (req_a)     return PORT_A;
    else                return PORT_B;
  endfunction

endpackage

// File: rtl/psram_rr_arb.sv
// Two-way round-robin grant: combinational pick, registered last-grant pointer.
module psram_rr_arb
  import psram_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_valid,
  output logic gnt_port
);

  logic last_grant;

  assign gnt_valid = en & (req_a | req_b);
  assign gnt_port  = rr_pick(req_a, req_b, last_grant);

  // Reset to B so that port A wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         last_grant <= PORT_B;
    else if (gnt_valid) last_grant <= gnt_port;
  end

endmodule

// File: rtl/psram_arbiter.sv
// Shares the PSRAM command engine between a capture writer (A) and a host
// port (B): latches the granted request, issues it, waits with timeout, gaps.
//   state | meaning
//   IDLE  | waiting for init_done and a request
//   ISSUE | one-cycle mem_start with the latched command
//   WAIT  | command held, waiting for mem_done or timeout
//   GAP   | CE-high spacing before the next grant
module psram_arbiter
  import psram_pkg::*;
#(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 16,
  parameter int TIMEOUT    = 1023,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_done,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              err,
  output logic              timeout_err,
  output logic              busy,
  output logic              mem_start,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata
);

  // One timer serves both WAIT and GAP, so it must hold the larger count.
  localparam int TMR_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP_CYCLES - 1);

  logic [1:0]       state;
  logic [TMR_W-1:0] timer;
  logic             cur_port;
  logic             arb_en;
  logic             gnt_valid;
  logic             gnt_port;
  logic             sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign arb_en    = (state == ST_IDLE) && init_done;
  assign busy      = (state != ST_IDLE);
  assign sel_we    = (gnt_port == PORT_A) ? a_we    : b_we;
  assign sel_addr  = (gnt_port == PORT_A) ? a_addr  : b_addr;
  assign sel_wdata = (gnt_port == PORT_A) ? a_wdata : b_wdata;

  psram_rr_arb u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (arb_en),
    .req_a     (a_req),
    .req_b     (b_req),
    .gnt_valid (gnt_valid),
    .gnt_port  (gnt_port)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      timer       <= '0;
      cur_port    <= PORT_A;
      mem_start   <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
      a_rdata     <= '0;
      b_rdata     <= '0;
      err         <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      mem_start <= 1'b0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      err       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            cur_port  <= gnt_port;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_read  <= ~sel_we;
            mem_write <= sel_we;
            mem_start <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          timer <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // mem_done is tested first so it wins over a same-cycle timeout.
          if (mem_done || timer == TO_LAST) begin
            if (cur_port == PORT_A) a_ack <= 1'b1;
            else                    b_ack <= 1'b1;
            if (mem_done) begin
              if (mem_read && cur_port == PORT_A) a_rdata <= mem_rdata;
              if (mem_read && cur_port == PORT_B) b_rdata <= mem_rdata;
            end else begin
              err         <= 1'b1;
              timeout_err <= 1'b1;
            end
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            timer     <= '0;
            state     <= ST_GAP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_GAP: begin
          if (timer == GAP_LAST) state <= ST_IDLE;
          else                   timer <= timer + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_arbiter.sv
// Bench for psram_arbiter: directed table, round-robin and reset sequences,
// then randomized contention checked against a transaction-level model.
module tb_psram_arbiter;

  localparam int AW = 24;
  localparam int DW = 16;
  localparam int TB_TO = 15;
  localparam int TB_GAP = 2;

  logic clk, rst_n, init_done;
  logic a_req, a_we, a_ack, b_req, b_we, b_ack;
  logic [AW-1:0] a_addr, b_addr, mem_addr;
  logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata, mem_wdata, mem_rdata;
  logic err, timeout_err, busy, mem_start, mem_read, mem_write, mem_done;

  psram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TB_TO), .GAP_CYCLES(TB_GAP)) dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .err(err), .timeout_err(timeout_err), .busy(busy),
    .mem_start(mem_start), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Engine model: answers mem_start with mem_done after eng_delay cycles (0 = never).
  int eng_delay;
  logic [DW-1:0] eng_rdata;
  int eng_cnt;
  bit eng_pend;
  initial begin
    mem_done = 1'b0; mem_rdata = '0; eng_delay = 0; eng_rdata = '0;
    eng_cnt = 0; eng_pend = 0;
    forever begin
      @(negedge clk);
      mem_done = 1'b0;
      if (mem_start) begin
        eng_pend = (eng_delay > 0);
        eng_cnt = eng_delay;
      end else if (eng_pend) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          mem_done = 1'b1;
          mem_rdata = eng_rdata;
          eng_pend = 0;
        end
      end
    end
  end

  // Requests as the bench issued them, and the reference model state.
  logic rq_we[2];
  logic [AW-1:0] rq_addr[2];
  logic [DW-1:0] rq_wdata[2];
  logic m_last;
  logic [DW-1:0] m_rd[2];
  logic m_sticky;

  task automatic drive(input int p, input logic r);
    if (p == 0) begin a_req = r; a_we = rq_we[0]; a_addr = rq_addr[0]; a_wdata = rq_wdata[0]; end
    else        begin b_req = r; b_we = rq_we[1]; b_addr = rq_addr[1]; b_wdata = rq_wdata[1]; end
  endtask

  task automatic serve(input int p, input int dly, input logic [DW-1:0] ret,
                       output int start_wait, output logic got_err, output logic [DW-1:0] got_rd);
    bit seen, acked, hold_ok, other_ack, pulse_ok, exp_to;
    int lat, g;
    logic [DW-1:0] exp_rd;
    seen = 0; acked = 0; hold_ok = 1; other_ack = 0; pulse_ok = 1; lat = 0;
    eng_delay = dly; eng_rdata = ret; start_wait = 0; got_err = 0; got_rd = '0;
    while (!seen && start_wait < 40) begin
      @(negedge clk);
      start_wait++;
      seen = mem_start;
    end
    chk("start_seen", {31'd0, seen}, 1);
    if (!seen) begin drive(p, 1'b0); return; end
    chk("grant_addr", {8'd0, mem_addr}, {8'd0, rq_addr[p]});
    chk("cmd_write", {31'd0, mem_write}, {31'd0, rq_we[p]});
    chk("cmd_read", {31'd0, mem_read}, {31'd0, ~rq_we[p]});
    chk("cmd_wdata", {16'd0, mem_wdata}, {16'd0, rq_wdata[p]});
    // Change the requester's fields after the grant; the command must not move.
    if (p == 0) begin a_addr = ~rq_addr[0]; a_wdata = ~rq_wdata[0]; a_we = ~rq_we[0]; end
    else        begin b_addr = ~rq_addr[1]; b_wdata = ~rq_wdata[1]; b_we = ~rq_we[1]; end
    while (!acked && lat < TB_TO + 10) begin
      @(negedge clk);
      lat++;
      acked = (p == 0) ? a_ack : b_ack;
      if ((p == 0) ? b_ack : a_ack) other_ack = 1;
      if (!acked && (mem_start || mem_addr !== rq_addr[p] || mem_wdata !== rq_wdata[p] ||
                     mem_write !== rq_we[p] || mem_read !== ~rq_we[p] || !busy)) hold_ok = 0;
    end
    drive(p, 1'b0);
    chk("ack_seen", {31'd0, acked}, 1);
    if (!acked) return;
    exp_to = (dly < 1 || dly > TB_TO);
    chk("cmd_hold", {31'd0, hold_ok}, 1);
    chk("other_ack", {31'd0, other_ack}, 0);
    chk("ack_latency", lat, exp_to ? TB_TO + 1 : dly + 1);
    got_err = err;
    got_rd = (p == 0) ? a_rdata : b_rdata;
    exp_rd = (rq_we[p] || exp_to) ? m_rd[p] : ret;
    chk("err", {31'd0, err}, {31'd0, exp_to});
    chk("rdata", {16'd0, got_rd}, {16'd0, exp_rd});
    m_rd[p] = exp_rd;
    m_sticky = m_sticky | exp_to;
    m_last = (p == 1);
    chk("timeout_err", {31'd0, timeout_err}, {31'd0, m_sticky});
    chk("ack_cmd_off", {30'd0, mem_read, mem_write}, 0);
    g = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0 && (a_ack || b_ack || err)) pulse_ok = 0;
      if (!busy) break;
      g++;
    end
    chk("ack_pulse", {31'd0, pulse_ok}, 1);
    chk("gap_len", g, TB_GAP);
  endtask

  typedef struct {
    int port; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata;
    int dly; logic [DW-1:0] ret; logic exp_err; logic [DW-1:0] exp_rd;
  } vec_t;
  vec_t vt[8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sw, n_start, n_busy, oc, acks;
    logic e;
    logic [DW-1:0] r;
    bit re_a, re_b, seen;
    logic order[4];

    rst_n = 0; init_done = 0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    m_last = 1; m_rd[0] = '0; m_rd[1] = '0; m_sticky = 0;
    vt[0] = '{0, 1'b0, 24'h000100, 16'h0000, 8,  16'hBEEF, 1'b0, 16'hBEEF};
    vt[1] = '{1, 1'b1, 24'hABCDEF, 16'h1234, 5,  16'h5555, 1'b0, 16'h0000};
    vt[2] = '{1, 1'b0, 24'h000200, 16'h0000, 1,  16'hCAFE, 1'b0, 16'hCAFE};
    vt[3] = '{0, 1'b1, 24'h000300, 16'h0F0F, 3,  16'h6666, 1'b0, 16'hBEEF};
    vt[4] = '{0, 1'b0, 24'h000400, 16'h0000, 15, 16'h1111, 1'b0, 16'h1111};
    vt[5] = '{1, 1'b0, 24'h000500, 16'h0000, 16, 16'h2222, 1'b1, 16'hCAFE};
    vt[6] = '{0, 1'b0, 24'h000600, 16'h0000, 0,  16'h7777, 1'b1, 16'h1111};
    vt[7] = '{1, 1'b0, 24'h000700, 16'h0000, 2,  16'h3333, 1'b0, 16'h3333};

    repeat (3) @(negedge clk);
    chk("rst_ctrl", {24'd0, a_ack, b_ack, err, timeout_err, busy, mem_start, mem_read, mem_write}, 0);
    chk("rst_addr", {8'd0, mem_addr}, 0);
    chk("rst_rdata", {a_rdata, b_rdata}, 0);
    rst_n = 1;

    // init_done low: requests are ignored.
    rq_we[0] = 1; rq_addr[0] = 24'h000055; rq_wdata[0] = 16'h7777;
    drive(0, 1'b1);
    n_start = 0; n_busy = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mem_start) n_start++;
      if (busy) n_busy++;
    end
    chk("noinit_starts", n_start, 0);
    chk("noinit_busy", n_busy, 0);
    init_done = 1;
    serve(0, 4, 16'h9999, sw, e, r);
    chk("init_start_latency", sw, 1);

    for (int i = 0; i < 8; i++) begin
      rq_we[vt[i].port] = vt[i].we;
      rq_addr[vt[i].port] = vt[i].addr;
      rq_wdata[vt[i].port] = vt[i].wdata;
      drive(vt[i].port, 1'b1);
      serve(vt[i].port, vt[i].dly, vt[i].ret, sw, e, r);
      chk($sformatf("tbl%0d_err", i), {31'd0, e}, {31'd0, vt[i].exp_err});
      chk($sformatf("tbl%0d_rdata", i), {16'd0, r}, {16'd0, vt[i].exp_rd});
    end

    // Both ports held; each drops after its ack and re-raises one cycle later.
    eng_delay = 3;
    rq_we[0] = 1; rq_addr[0] = 24'h0A0000; rq_wdata[0] = 16'hAAAA;
    rq_we[1] = 1; rq_addr[1] = 24'h8B0000; rq_wdata[1] = 16'hBBBB;
    drive(0, 1'b1); drive(1, 1'b1);
    oc = 0; acks = 0; re_a = 0; re_b = 0;
    for (int n = 0; n < 300 && acks < 4; n++) begin
      @(negedge clk);
      if (mem_start && oc < 4) begin order[oc] = mem_addr[23]; oc++; end
      if (re_a) begin a_req = 1; re_a = 0; end
      if (re_b) begin b_req = 1; re_b = 0; end
      if (a_ack) begin a_req = 0; acks++; re_a = (acks <= 2); end
      if (b_ack) begin b_req = 0; acks++; re_b = (acks <= 2); end
    end
    a_req = 0; b_req = 0;
    chk("rr_starts", oc, 4);
    chk("rr_acks", acks, 4);
    for (int i = 0; i < oc; i++) chk($sformatf("rr_order%0d", i), {31'd0, order[i]}, i % 2);
    for (int n = 0; n < 20 && busy; n++) @(negedge clk);
    m_last = 1;

    // Reset while an A read sits in WAIT.
    @(negedge clk);
    rq_we[0] = 0; rq_addr[0] = 24'h012345; rq_wdata[0] = 16'h0;
    eng_delay = 0;
    drive(0, 1'b1);
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin @(negedge clk); seen = mem_start; end
    chk("rstw_start_seen", {31'd0, seen}, 1);
    @(negedge clk); @(negedge clk);
    chk("rstw_busy", {31'd0, busy}, 1);
    rst_n = 0; a_req = 0;
    #1;
    chk("rstw_ctrl", {24'd0, a_ack, b_ack, err, timeout_err, busy, mem_start, mem_read, mem_write}, 0);
    chk("rstw_addr", {8'd0, mem_addr}, 0);
    chk("rstw_wdata", {16'd0, mem_wdata}, 0);
    chk("rstw_rdata", {a_rdata, b_rdata}, 0);
    @(negedge clk);
    rst_n = 1;
    m_last = 1; m_rd[0] = '0; m_rd[1] = '0; m_sticky = 0;
    rq_we[0] = 0; rq_addr[0] = 24'h000777; rq_wdata[0] = 16'h0;
    rq_we[1] = 0; rq_addr[1] = 24'h800888; rq_wdata[1] = 16'h0;
    drive(0, 1'b1); drive(1, 1'b1);
    serve(0, 3, 16'h4444, sw, e, r);
    serve(1, 2, 16'h5555, sw, e, r);

    // Random contention against the transaction-level model.
    for (int it = 0; it < 30; it++) begin
      int pat, exp_p, dly;
      bit pend[2];
      pat = $urandom_range(1, 3);
      for (int p = 0; p < 2; p++) begin
        pend[p] = pat[p];
        if (pend[p]) begin
          rq_we[p] = 1'($urandom_range(0, 1));
          rq_addr[p] = {p[0], 23'($urandom)};
          rq_wdata[p] = 16'($urandom);
        end
      end
      @(negedge clk);
      for (int p = 0; p < 2; p++) if (pend[p]) drive(p, 1'b1);
      while (pend[0] || pend[1]) begin
        exp_p = (pend[0] && pend[1]) ? (m_last ? 0 : 1) : (pend[0] ? 0 : 1);
        dly = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1) * (TB_TO + 1)
                                          : $urandom_range(1, TB_TO);
        serve(exp_p, dly, 16'($urandom), sw, e, r);
        pend[exp_p] = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
